// File: rtl/aibnd_red_clksel_ctl.sv
// Break-before-make sequencer for the one-hot selects of the 3:1 redundancy clock mux.
// Selects drop, a dead gap follows, then the new select rises and is held to settle before ack.
module aibnd_red_clksel_ctl #(
  parameter int GAP_CYC    = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_vld,
  input  logic [1:0] req_sel,
  output logic       req_rdy,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic [1:0] sel_cur,
  output logic       busy,
  output logic       ack,
  input  logic       vccl_aibnd,
  input  logic       vssl_aibnd
);

  typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_MAKE, ST_ACK} state_t;

  localparam logic [3:0] GAP_LOAD    = 4'(GAP_CYC - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_cnt;
  logic [1:0] r_target;
  logic [1:0] r_selCur;
  logic [2:0] r_sel;
  logic       w_accept;
  logic       w_sameCode;
  logic       w_cntZero;
  logic       w_unusedPwr;

  function automatic logic [2:0] decodeSel(input logic [1:0] code);
    case (code)
      2'b01:   decodeSel = 3'b001;
      2'b10:   decodeSel = 3'b010;
      2'b11:   decodeSel = 3'b100;
      default: decodeSel = 3'b000;
    endcase
  endfunction

  // Supply pins carry no logic; folded here so they are not left dangling.
  assign w_unusedPwr = vccl_aibnd ^ vssl_aibnd;

  assign w_accept   = req_vld && (r_state == ST_IDLE);
  assign w_sameCode = (req_sel == r_selCur);
  assign w_cntZero  = (r_cnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nextState = w_sameCode ? ST_ACK : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (w_cntZero) begin
          w_nextState = (r_target == 2'b00) ? ST_ACK : ST_MAKE;
        end
      end
      ST_MAKE: begin
        if (w_cntZero) begin
          w_nextState = ST_ACK;
        end
      end
      ST_ACK:  w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Selects only ever go all-low on accept and one-hot on entering MAKE, so no hop is possible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 4'd0;
      r_target <= 2'b00;
      r_selCur <= 2'b00;
      r_sel    <= 3'b000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_sameCode) begin
            r_cnt    <= GAP_LOAD;
            r_target <= req_sel;
            r_sel    <= 3'b000;
          end
        end
        ST_BREAK: begin
          if (w_cntZero) begin
            r_selCur <= r_target;
            if (r_target != 2'b00) begin
              r_cnt <= SETTLE_LOAD;
              r_sel <= decodeSel(r_target);
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_MAKE: begin
          if (!w_cntZero) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    req_rdy = (r_state == ST_IDLE);
    busy    = (r_state != ST_IDLE);
    ack     = (r_state == ST_ACK);
  end

  assign s1      = r_sel[0];
  assign s2      = r_sel[1];
  assign s3      = r_sel[2];
  assign sel_cur = r_selCur;

endmodule

// File: tb/tb_aibnd_red_clksel_ctl.sv
// Scoreboard bench for aibnd_red_clksel_ctl: a per-cycle timeline model plus an ack queue
// checked by a separate monitor; directed scenarios followed by randomized requests.
module tb_aibnd_red_clksel_ctl;

  localparam int GAP    = 4;
  localparam int SETTLE = 2;

  typedef struct {
    int         ackCyc;
    logic [1:0] selCode;
    logic [2:0] selVec;
  } ackExp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reqVld = 1'b0;
  logic [1:0] reqSel = 2'b00;
  logic       reqRdy;
  logic       s1, s2, s3;
  logic [1:0] selCur;
  logic       busy;
  logic       ack;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int acceptCnt = 0;

  ackExp_t scoreQ[$];

  // Reference model: the last accepted request and when it was taken.
  bit         mPending = 1'b0;
  logic [1:0] mCur = 2'b00;
  logic [1:0] mOld = 2'b00;
  logic [1:0] mNew = 2'b00;
  int         mT = 0;
  int         mAckCyc = 0;
  logic [2:0] prevVec = 3'b000;

  aibnd_red_clksel_ctl #(.GAP_CYC(GAP), .SETTLE_CYC(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_vld    (reqVld),
    .req_sel    (reqSel),
    .req_rdy    (reqRdy),
    .s1         (s1),
    .s2         (s2),
    .s3         (s3),
    .sel_cur    (selCur),
    .busy       (busy),
    .ack        (ack),
    .vccl_aibnd (1'b1),
    .vssl_aibnd (1'b0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] oneHot(input logic [1:0] code);
    oneHot = (code == 2'b00) ? 3'b000 : 3'(1 << (code - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Timeline model: expected outputs follow from the accept cycle and the GAP/SETTLE arithmetic.
  always @(negedge clk) begin
    logic [2:0] expVec;
    logic [1:0] expCur;
    logic       expRdy;
    logic       expAck;
    logic [2:0] vec;
    if (reset) begin
      mPending = 1'b0;
      mCur     = 2'b00;
      prevVec  = 3'b000;
      scoreQ.delete();
    end else begin
      if (mPending && cyc > mAckCyc) begin
        mPending = 1'b0;
        mCur     = mNew;
      end
      if (!mPending) begin
        expVec = oneHot(mCur);
        expCur = mCur;
        expRdy = 1'b1;
        expAck = 1'b0;
      end else begin
        if (mNew == mOld) begin
          expVec = oneHot(mOld);
          expCur = mOld;
        end else begin
          expVec = (cyc <= mT + GAP) ? 3'b000 : oneHot(mNew);
          expCur = (cyc >= mT + GAP + 1) ? mNew : mOld;
        end
        expRdy = 1'b0;
        expAck = (cyc == mAckCyc);
      end
      vec = {s3, s2, s1};
      checkOutput("selects", 32'(vec), 32'(expVec));
      checkOutput("sel_cur", 32'(selCur), 32'(expCur));
      checkOutput("req_rdy", 32'(reqRdy), 32'(expRdy));
      checkOutput("busy", 32'(busy), 32'(!expRdy));
      checkOutput("ack", 32'(ack), 32'(expAck));
      checkOutput("oneHotOrZero", 32'($countones(vec) <= 1), 32'd1);
      checkOutput("noDirectHop", 32'(((prevVec & ~vec) != 3'b000) && ((vec & ~prevVec) != 3'b000)), 32'd0);
      prevVec = vec;
      if (reqVld && expRdy) begin
        ackExp_t e;
        mPending = 1'b1;
        mT       = cyc;
        mOld     = mCur;
        mNew     = reqSel;
        if (mNew == mOld)        mAckCyc = mT + 1;
        else if (mNew == 2'b00)  mAckCyc = mT + GAP + 1;
        else                     mAckCyc = mT + GAP + SETTLE + 1;
        e.ackCyc  = mAckCyc;
        e.selCode = mNew;
        e.selVec  = oneHot(mNew);
        scoreQ.push_back(e);
        acceptCnt++;
      end
    end
  end

  // Ack monitor: every ack must match the oldest outstanding accepted request.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack) begin
        if (scoreQ.size() == 0) begin
          checkOutput("ackUnexpected", 32'd1, 32'd0);
        end else begin
          ackExp_t e;
          e = scoreQ.pop_front();
          checkOutput("ackCycle", 32'(cyc), 32'(e.ackCyc));
          checkOutput("ackSelCur", 32'(selCur), 32'(e.selCode));
          checkOutput("ackSelects", 32'({s3, s2, s1}), 32'(e.selVec));
        end
      end else if (scoreQ.size() > 0 && scoreQ[0].ackCyc < cyc) begin
        checkOutput("ackMissing", 32'd0, 32'd1);
        void'(scoreQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] sel);
    int startCnt;
    bit got;
    startCnt = acceptCnt;
    got      = 1'b0;
    reqSel   = sel;
    reqVld   = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      if (acceptCnt != startCnt) begin
        got = 1'b1;
        break;
      end
    end
    #2;
    reqVld = 1'b0;
    if (!got) checkOutput("acceptTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    $display("[TB] start, GAP=%0d SETTLE=%0d", GAP, SETTLE);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("resetSelects", 32'({s3, s2, s1}), 32'd0);
    checkOutput("resetSelCur", 32'(selCur), 32'd0);
    checkOutput("resetRdy", 32'(reqRdy), 32'd1);
    checkOutput("resetAck", 32'(ack), 32'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;

    applyStimulus(2'b01);
    repeat (3) @(posedge clk);
    applyStimulus(2'b11);
    applyStimulus(2'b10);
    repeat (2) @(posedge clk);
    applyStimulus(2'b10);
    applyStimulus(2'b00);
    applyStimulus(2'b00);

    // Requests held with a wandering code while busy must not be taken.
    reqVld = 1'b1;
    reqSel = 2'b01;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      reqSel = 2'($urandom_range(0, 3));
    end
    reqVld = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    applyStimulus(2'b00);

    // Reset in the middle of MAKE with s2 high.
    applyStimulus(2'b10);
    repeat (GAP) @(posedge clk);
    #2;
    checkOutput("preResetS2", 32'(s2), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("asyncResetS2", 32'(s2), 32'd0);
    checkOutput("asyncResetSelCur", 32'(selCur), 32'd0);
    checkOutput("asyncResetAck", 32'(ack), 32'd0);
    checkOutput("asyncResetRdy", 32'(reqRdy), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(2'b01);
    repeat (10) @(posedge clk);
    #2;

    for (int i = 0; i < 400; i++) begin
      reqVld = ($urandom_range(0, 3) == 0);
      reqSel = 2'($urandom_range(0, 3));
      @(posedge clk);
      #2;
    end
    reqVld = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    checkOutput("scoreboardDrained", 32'(scoreQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/aibnd_red_clksel_ctl.md
Name: aibnd_red_clksel_ctl

Overview:
- Sequencer that generates the one-hot select lines s1/s2/s3 for the 3:1 redundancy clock mux (aibnd_red_clkmux3).
- Accepts a requested clock source over a valid/ready handshake.
- Switches with strict break-before-make: old select low, dead gap, new select high. The mux therefore never sees two selects high, and never sees a direct select-to-select hop that produces a runt clock or an X output.
- Sits in the redundancy control path beside the mux.

Parameters:
- GAP_CYC, default 4: dead cycles with all selects low between deasserting the old select and asserting the new one; legal range 1..15.
- SETTLE_CYC, default 2: cycles the new select is held before ack, allowing the mux output to settle; legal range 1..15.

Ports:
- clk  input  1  controller clock
- reset  input  1  asynchronous, active-high reset
- req_vld  input  1  request valid
- req_sel  input  2  requested source: 00 park (all off), 01 clk1, 10 clk2, 11 clk3
- req_rdy  output  1  controller idle; a request is accepted when req_vld && req_rdy on a clk rising edge
- s1  output  1  select clk1 (registered)
- s2  output  1  select clk2 (registered)
- s3  output  1  select clk3 (registered)
- sel_cur  output  2  currently committed source code, same encoding as req_sel
- busy  output  1  inverse of req_rdy
- ack  output  1  one-cycle pulse when a switch completes
- vccl_aibnd  input  1  power pin, no logic function
- vssl_aibnd  input  1  ground pin, no logic function

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values (also applied asynchronously mid-operation): s1=s2=s3=0, sel_cur=00, req_rdy=1, busy=0, ack=0, state IDLE, counter 0.
  - An in-flight switch is abandoned; no ack is issued.
- State machine: IDLE, BREAK, MAKE, ACK.
- IDLE:
  - req_rdy=1.
  - On accept with req_sel==sel_cur: go to ACK; selects unchanged.
  - On accept with req_sel!=sel_cur: go to BREAK; load counter with GAP_CYC-1; latch target=req_sel.
- BREAK:
  - s1..s3 all 0.
  - Counter decrements each cycle.
  - At count 0: if target==00, go to ACK with sel_cur=00; else go to MAKE, load counter with SETTLE_CYC-1, drive the target's select high.
- MAKE:
  - Exactly one select high, per target.
  - sel_cur=target from the first MAKE cycle.
  - At count 0, go to ACK.
- ACK: ack=1 for one cycle, req_rdy=0; next state IDLE.
- Timing, request accepted at edge ending cycle T:
  - All selects low in cycles T+1 .. T+GAP_CYC.
  - New select high from T+GAP_CYC+1.
  - ack at T+GAP_CYC+SETTLE_CYC+1.
  - req_rdy high again at T+GAP_CYC+SETTLE_CYC+2.
  - Same-code request: ack at T+1, req_rdy at T+2.
  - Park request: ack at T+GAP_CYC+1.
- The BREAK gap applies on every code change, including from park (00) to a clock.
- Handshake:
  - req_vld while busy is ignored: not queued, not latched.
  - req_sel is sampled only on accept; changes after accept have no effect on the in-flight switch.
- Invariants, at every cycle:
  - s1+s2+s3 <= 1.
  - No cycle has one select falling while another rises.
  - {s3,s2,s1} is never a non-one-hot nonzero value.
- Outputs s1..s3 come directly from flops (glitch-free). sel_cur, busy, req_rdy and ack are registered or decoded from state only.
- Counter width: 4 bits, saturating is not needed since the load value is at most 14.

Test Plan:
1. Reset released, no request -> s1..s3=000, sel_cur=00, req_rdy=1 and held for 20 cycles; ack never asserted.
2. GAP=4, SETTLE=2; accept req_sel=01 at cycle 10 -> selects 000 in cycles 11-14; s1=1 from 15; sel_cur=01 at 15; ack pulse at 17 only; req_rdy=1 at 18.
3. From sel_cur=01, request 11 -> s1 falls at T+1; all low T+1..T+4; s3 rises T+5; ack at T+7. A checker asserts one-hot-or-zero on every cycle.
4. From sel_cur=10, request 10 -> no select change; ack at T+1. Then request 00 -> s2 low at T+1; ack at T+5; sel_cur=00.
5. req_vld held high with varying req_sel during BREAK/MAKE -> no additional accepts; target unchanged; exactly one ack per accepted request.
6. Assert reset during MAKE (s2=1) -> s2=0 asynchronously before the next clk edge; sel_cur=00; no ack. After release a new request to 01 completes with normal timing.
